// File: rtl/instr_decode.sv
// SPI command decoder: turns synchronized bridge bytes into register-file
// read/write strobes and returns read data on data_out for MISO.
module instr_decode #(
    parameter int ADDR_W      = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              byte_sync,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data_write,
    input  logic [7:0]        data_read
);

    typedef enum logic [1:0] {
        IDLE,
        RD_REQ,
        RD_CAP,
        DATA
    } state_t;

    logic [SYNC_STAGES-1:0] bs_sync_reg;
    logic [SYNC_STAGES-1:0] cs_sync_reg;
    logic                   bs_prev_reg;
    logic                   byte_evt;
    logic                   cs_high;

    state_t                 state_reg;
    logic                   rw_reg;
    logic                   burst_reg;
    logic                   done_reg;
    logic [ADDR_W-1:0]      addr_reg;
    logic [7:0]             data_out_reg;
    logic [7:0]             data_write_reg;
    logic                   read_reg;
    logic                   write_reg;

    // cs_n synchronizer idles high so a reset never looks like a selected frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bs_sync_reg <= '0;
            cs_sync_reg <= '1;
            bs_prev_reg <= 1'b0;
        end else begin
            bs_sync_reg <= {bs_sync_reg[SYNC_STAGES-2:0], byte_sync};
            cs_sync_reg <= {cs_sync_reg[SYNC_STAGES-2:0], cs_n};
            bs_prev_reg <= bs_sync_reg[SYNC_STAGES-1];
        end
    end

    assign byte_evt = bs_sync_reg[SYNC_STAGES-1] & ~bs_prev_reg;
    assign cs_high  = cs_sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            rw_reg         <= 1'b0;
            burst_reg      <= 1'b0;
            done_reg       <= 1'b0;
            addr_reg       <= '0;
            data_out_reg   <= '0;
            data_write_reg <= '0;
            read_reg       <= 1'b0;
            write_reg      <= 1'b0;
        end else begin
            read_reg  <= 1'b0;
            write_reg <= 1'b0;

            // Burst writes advance the address only after the strobe cycle,
            // so addr stays put while write is high.
            if (write_reg && burst_reg) begin
                addr_reg <= addr_reg + ADDR_W'(1);
            end

            if (cs_high) begin
                state_reg <= IDLE;
                rw_reg    <= 1'b0;
                burst_reg <= 1'b0;
                done_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (byte_evt && !done_reg) begin
                            rw_reg    <= data_in[7];
                            burst_reg <= data_in[6];
                            addr_reg  <= data_in[ADDR_W-1:0];
                            if (data_in[7]) begin
                                state_reg <= DATA;
                            end else begin
                                state_reg <= RD_REQ;
                                read_reg  <= 1'b1;
                            end
                        end
                    end
                    RD_REQ: begin
                        state_reg <= RD_CAP;
                    end
                    RD_CAP: begin
                        data_out_reg <= data_read;
                        state_reg    <= DATA;
                    end
                    DATA: begin
                        if (byte_evt) begin
                            if (rw_reg) begin
                                write_reg      <= 1'b1;
                                data_write_reg <= data_in;
                            end
                            if (!burst_reg) begin
                                state_reg <= IDLE;
                                done_reg  <= 1'b1;
                            end else if (!rw_reg) begin
                                // Prefetch the next register for the following dummy byte.
                                addr_reg  <= addr_reg + ADDR_W'(1);
                                read_reg  <= 1'b1;
                                state_reg <= RD_REQ;
                            end
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign data_out   = data_out_reg;
    assign read       = read_reg;
    assign write      = write_reg;
    assign addr       = addr_reg;
    assign data_write = data_write_reg;

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: directed vectors, corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_instr_decode;

    logic       clk;
    logic       rst_n;
    logic       cs_n;
    logic       byte_sync;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       read;
    logic       write;
    logic [5:0] addr;
    logic [7:0] data_write;
    logic [7:0] data_read;

    instr_decode #(.ADDR_W(6), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs_n       (cs_n),
        .byte_sync  (byte_sync),
        .data_in    (data_in),
        .data_out   (data_out),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .data_write (data_write),
        .data_read  (data_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       w;
        logic [5:0] a;
        logic [7:0] d;
    } strobe_t;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d2;
        int         nd;
        int         exp_n;
        logic [5:0] exp_last_addr;
        logic [7:0] exp_dout;
    } vec_t;

    strobe_t    obs[$];
    strobe_t    exq[$];
    logic [7:0] mem  [64];
    logic [7:0] gold [64];
    logic [7:0] exp_dout;
    logic       init_req;
    int         both_cnt;
    int         total;
    int         bad;
    vec_t       vecs [4];

    function automatic logic [7:0] init_val(input int i);
        case (i)
            0:       return 8'h10;
            1:       return 8'h20;
            2:       return 8'h30;
            3:       return 8'h44;
            18:      return 8'hA7;
            default: return 8'(i * 5 + 7);
        endcase
    endfunction

    // Register file attached to the decoder: registered read, one-clk latency.
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
        end else begin
            if (write) mem[addr] <= data_write;
            if (read)  data_read <= mem[addr];
        end
    end

    always @(negedge clk) begin
        if (read || write) obs.push_back('{w: write, a: addr, d: (write ? data_write : 8'h00)});
        if (read && write) both_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        data_in   = b;
        byte_sync = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        byte_sync = 1'b0;
        repeat (24) @(posedge clk);
        #1;
    endtask

    // Reference: byte k of a read frame triggers a read of start+k (only k=0
    // without burst); byte k>=1 of a write frame writes start+k-1 (only k=1
    // without burst). data_out follows the most recent read.
    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3, input int nd, input int hold);
        logic [7:0] bytes [5];
        logic [5:0] a;
        logic [5:0] ea;
        bytes = '{cmd, d0, d1, d2, d3};
        a = cmd[5:0];
        obs.delete();
        exq.delete();
        cs_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k <= nd; k++) begin
            send_byte(bytes[k], hold);
            if (!cmd[7]) begin
                if (k == 0 || cmd[6]) begin
                    ea = a + 6'(k);
                    exq.push_back('{w: 1'b0, a: ea, d: 8'h00});
                    exp_dout = gold[ea];
                end
            end else if (k >= 1 && (k == 1 || cmd[6])) begin
                ea = a + 6'(k - 1);
                exq.push_back('{w: 1'b1, a: ea, d: bytes[k]});
                gold[ea] = bytes[k];
            end
            check("dout", 32'(data_out), 32'(exp_dout));
        end
        cs_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("strobe_count", 32'(obs.size()), 32'(exq.size()));
        for (int i = 0; i < exq.size() && i < obs.size(); i++)
            check("strobe", 32'(obs[i]), 32'(exq[i]));
        $display("frame cmd=%02h bytes=%0d strobes=%0d dout=%02h", cmd, nd, obs.size(), data_out);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        both_cnt  = 0;
        exp_dout  = 8'h00;
        cs_n      = 1'b1;
        byte_sync = 1'b0;
        data_in   = 8'h00;
        rst_n     = 1'b0;
        init_req  = 1'b1;
        for (int i = 0; i < 64; i++) gold[i] = init_val(i);

        vecs[0] = '{8'h85, 8'h3C, 8'h00, 8'h00, 1, 1, 6'd5,  8'hA7};
        vecs[1] = '{8'h40, 8'h00, 8'h00, 8'h00, 3, 4, 6'd3,  8'h44};
        vecs[2] = '{8'hFE, 8'h11, 8'h22, 8'h33, 3, 3, 6'd0,  8'h44};
        vecs[3] = '{8'h85, 8'h3C, 8'h77, 8'h00, 2, 1, 6'd5,  8'h44};

        repeat (3) @(posedge clk);
        #1;
        init_req = 1'b0;
        check("reset_outputs", 32'({data_out, read, write, addr, data_write}), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Single read with exact latency: data_out updates on the 5th edge after byte_sync rises.
        obs.delete();
        cs_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        data_in   = 8'h12;
        byte_sync = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("dout_before_capture", 32'(data_out), 32'h00);
        @(posedge clk);
        #1;
        check("dout_latency", 32'(data_out), 32'hA7);
        byte_sync = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        send_byte(8'h00, 8);
        cs_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        exp_dout = 8'hA7;
        check("single_read_count", 32'(obs.size()), 32'd1);
        if (obs.size() > 0) check("single_read_strobe", 32'(obs[0]), 32'({1'b0, 6'h12, 8'h00}));
        $display("frame cmd=12 bytes=1 strobes=%0d dout=%02h", obs.size(), data_out);

        for (int v = 0; v < 4; v++) begin
            run_frame(vecs[v].cmd, vecs[v].d0, vecs[v].d1, vecs[v].d2, 8'h00, vecs[v].nd, 8);
            check("vec_count", 32'(obs.size()), 32'(vecs[v].exp_n));
            if (obs.size() > 0)
                check("vec_last_addr", 32'(obs[obs.size()-1].a), 32'(vecs[v].exp_last_addr));
            check("vec_dout", 32'(data_out), 32'(vecs[v].exp_dout));
        end

        // Stretched byte_sync during a burst write yields one event only.
        run_frame(8'hC8, 8'hAB, 8'h00, 8'h00, 8'h00, 1, 20);
        check("stretch_count", 32'(obs.size()), 32'd1);

        // Abort after the command byte: no write.
        obs.delete();
        cs_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        send_byte(8'h85, 8);
        cs_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_strobe", 32'(obs.size()), 32'd0);
        $display("frame cmd=85 aborted strobes=%0d", obs.size());

        // Reset while in DATA of a burst write.
        obs.delete();
        cs_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        send_byte(8'hC4, 8);
        send_byte(8'h99, 8);
        gold[4] = 8'h99;
        check("pre_reset_write", 32'(obs.size()), 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_async_outputs", 32'({data_out, read, write, addr, data_write}), 32'd0);
        cs_n = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_dout = 8'h00;
        repeat (6) @(posedge clk);
        #1;
        $display("reset applied mid-frame");
        run_frame(8'h83, 8'h55, 8'h00, 8'h00, 8'h00, 1, 8);
        if (obs.size() > 0) check("post_reset_write", 32'(obs[0]), 32'({1'b1, 6'd3, 8'h55}));

        for (int r = 0; r < 40; r++) begin
            run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                      int'($urandom_range(0, 4)), int'($urandom_range(3, 12)));
        end

        check("read_write_exclusive", 32'(both_cnt), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
